// File: rtl/mac_loop_counter_if.sv
// Handshake bundle between the MAC controller FSM and its loop counter.
// The controller drives load/step requests; the counter returns count and status.
interface mac_loop_counter_if #(
    parameter int WIDTH  = 16,
    parameter int WRAP_W = 8
);
    logic [WIDTH-1:0]  N;
    logic              ld_N;
    logic              dec_N;
    logic              inc_N;
    logic              auto_rl;
    logic [WIDTH-1:0]  dout;
    logic              zero;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              sat;

    modport master (
        output N, ld_N, dec_N, inc_N, auto_rl,
        input  dout, zero, tc, wrap_cnt, sat
    );

    modport slave (
        input  N, ld_N, dec_N, inc_N, auto_rl,
        output dout, zero, tc, wrap_cnt, sat
    );
endinterface

// File: rtl/mac_loop_counter.sv
// Loop counter for the MAC controller: load, up/down step without wrap,
// auto-reload on terminal decrement, registered terminal-count pulse and status.
module mac_loop_counter #(
    parameter int WIDTH  = 16,
    parameter int WRAP_W = 8
) (
    input  logic                 clk,
    input  logic                 clr,
    mac_loop_counter_if.slave    bus
);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0]  dout_q,   dout_d;
    logic [WIDTH-1:0]  rl_val_q, rl_val_d;
    logic [WRAP_W-1:0] wrap_q,   wrap_d;
    logic              tc_q,     tc_d;
    logic              sat_q,    sat_d;

    // The reload-event counter sticks at all-ones instead of wrapping.
    function automatic logic [WRAP_W-1:0] sat_inc_wrap(input logic [WRAP_W-1:0] v);
        return (v == {WRAP_W{1'b1}}) ? v : v + WRAP_W'(1);
    endfunction

    always_comb begin
        dout_d   = dout_q;
        rl_val_d = rl_val_q;
        wrap_d   = wrap_q;
        tc_d     = 1'b0;
        sat_d    = sat_q;
        if (bus.ld_N) begin
            dout_d   = bus.N;
            rl_val_d = bus.N;
            sat_d    = 1'b0;
        end else if (bus.dec_N && !bus.inc_N) begin
            if (dout_q > ONE) begin
                dout_d = dout_q - ONE;
            end else if (dout_q == ONE) begin
                tc_d = 1'b1;
                if (bus.auto_rl) begin
                    dout_d = rl_val_q;
                    wrap_d = sat_inc_wrap(wrap_q);
                end else begin
                    dout_d = '0;
                end
            end
        end else if (bus.inc_N && !bus.dec_N) begin
            if (dout_q != ALL_ONES) begin
                dout_d = dout_q + ONE;
            end else begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dout_q   <= '0;
            rl_val_q <= '0;
            wrap_q   <= '0;
            tc_q     <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            rl_val_q <= rl_val_d;
            wrap_q   <= wrap_d;
            tc_q     <= tc_d;
            sat_q    <= sat_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.zero     = (dout_q == '0);
    assign bus.tc       = tc_q;
    assign bus.wrap_cnt = wrap_q;
    assign bus.sat      = sat_q;
endmodule

// File: tb/tb_mac_loop_counter.sv
// Bench for mac_loop_counter: directed scenarios plus random traffic,
// checked every cycle against an integer reference model of the counter.
module tb_mac_loop_counter;
    localparam int WIDTH  = 16;
    localparam int WRAP_W = 8;
    localparam longint MAXV = (longint'(1) << WIDTH) - 1;
    localparam longint WMAX = (longint'(1) << WRAP_W) - 1;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mac_loop_counter_if #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) bus ();

    mac_loop_counter #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    longint m_cnt, m_rl, m_wrap;
    bit     m_tc, m_sat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour: one clock edge of the counter in plain arithmetic.
    task automatic model_step(input bit c, input bit ld, input bit dec, input bit inc,
                              input bit arl, input longint n);
        if (c) begin
            m_cnt = 0; m_rl = 0; m_wrap = 0; m_tc = 0; m_sat = 0;
        end else if (ld) begin
            m_cnt = n; m_rl = n; m_tc = 0; m_sat = 0;
        end else begin
            m_tc = 0;
            if (dec && !inc) begin
                if (m_cnt > 1) m_cnt = m_cnt - 1;
                else if (m_cnt == 1) begin
                    m_tc = 1;
                    if (arl) begin
                        m_cnt = m_rl;
                        if (m_wrap < WMAX) m_wrap = m_wrap + 1;
                    end else m_cnt = 0;
                end
            end else if (inc && !dec) begin
                if (m_cnt < MAXV) m_cnt = m_cnt + 1;
                else m_sat = 1;
            end
        end
    endtask

    task automatic compare_model();
        check("dout",     32'(bus.dout),     32'(m_cnt));
        check("zero",     32'(bus.zero),     32'(m_cnt == 0));
        check("tc",       32'(bus.tc),       32'(m_tc));
        check("wrap_cnt", 32'(bus.wrap_cnt), 32'(m_wrap));
        check("sat",      32'(bus.sat),      32'(m_sat));
    endtask

    // Drive one cycle's inputs, let the edge happen, advance model, check at negedge.
    task automatic drive(input bit c, input bit ld, input bit dec, input bit inc,
                         input bit arl, input longint n);
        clr         = c;
        bus.ld_N    = ld;
        bus.dec_N   = dec;
        bus.inc_N   = inc;
        bus.auto_rl = arl;
        bus.N       = WIDTH'(n);
        @(posedge clk);
        model_step(c, ld, dec, inc, arl, n);
        @(negedge clk);
        compare_model();
    endtask

    int exp_a[9];
    int exp_t[9];

    initial begin
        clr = 1'b1; bus.ld_N = 0; bus.dec_N = 0; bus.inc_N = 0; bus.auto_rl = 0; bus.N = '0;
        m_cnt = 0; m_rl = 0; m_wrap = 0; m_tc = 0; m_sat = 0;
        @(negedge clk);

        // Reset then load
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        check("rst_dout", 32'(bus.dout), 0);
        check("rst_zero", 32'(bus.zero), 1);
        check("rst_tc",   32'(bus.tc), 0);
        drive(0, 1, 0, 0, 0, 7);
        check("ld7_dout", 32'(bus.dout), 7);
        check("ld7_zero", 32'(bus.zero), 0);
        check("ld7_wrap", 32'(bus.wrap_cnt), 0);

        // Countdown, no reload
        drive(0, 1, 0, 0, 0, 3);
        exp_a[0:4] = '{2, 1, 0, 0, 0};
        exp_t[0:4] = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            check("cd_dout", 32'(bus.dout), 32'(exp_a[i]));
            check("cd_tc",   32'(bus.tc),   32'(exp_t[i]));
        end
        check("cd_zero", 32'(bus.zero), 1);

        // Auto-reload
        drive(0, 1, 0, 0, 1, 3);
        exp_a = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 0, 1, 0);
            check("ar_dout", 32'(bus.dout), 32'(exp_a[i]));
            check("ar_tc",   32'(bus.tc),   32'(exp_a[i] == 3));
        end
        check("ar_wrap", 32'(bus.wrap_cnt), 3);

        // Increment saturation
        drive(0, 1, 0, 0, 0, 'hFFFE);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0);
            check("inc_dout", 32'(bus.dout), 32'hFFFF);
            check("inc_sat",  32'(bus.sat),  32'(i > 0));
        end
        drive(0, 1, 0, 0, 0, 4);
        check("ld_clr_sat", 32'(bus.sat), 0);

        // Simultaneous events
        drive(0, 1, 0, 0, 0, 5);
        drive(0, 0, 1, 1, 0, 0);
        check("decinc_hold", 32'(bus.dout), 5);
        drive(0, 1, 1, 0, 0, 9);
        check("lddec", 32'(bus.dout), 9);
        drive(1, 1, 0, 0, 0, 9);
        check("clrld", 32'(bus.dout), 0);

        // Reset mid-operation
        drive(0, 1, 0, 0, 1, 2);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 1, 0);
        check("mid_wrap2", 32'(bus.wrap_cnt), 2);
        drive(1, 0, 1, 0, 1, 0);
        check("mid_dout", 32'(bus.dout), 0);
        check("mid_wrap", 32'(bus.wrap_cnt), 0);
        check("mid_tc",   32'(bus.tc), 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 0, 1, 0);
        check("mid_hold0", 32'(bus.dout), 0);

        // rl_val == 1 pulses tc every cycle and saturates the wrap counter
        drive(0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 300; i++) drive(0, 0, 1, 0, 1, 0);
        check("rl1_tc",   32'(bus.tc), 1);
        check("rl1_dout", 32'(bus.dout), 1);
        check("wrap_sat", 32'(bus.wrap_cnt), 32'hFF);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bit c, ld, dec, inc, arl;
            longint n;
            int sel;
            c   = ($urandom_range(0, 99) == 0);
            ld  = ($urandom_range(0, 9) == 0);
            dec = ($urandom_range(0, 99) < 60);
            inc = ($urandom_range(0, 99) < 25);
            arl = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0: n = 0;
                1: n = 1;
                2: n = $urandom_range(2, 6);
                3: n = MAXV - $urandom_range(0, 2);
                default: n = longint'($urandom_range(0, 32'(MAXV)));
            endcase
            drive(c, ld, dec, inc, arl, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
